// File: rtl/coherent_averager.sv
// ---------------------------------------------------------------------------
// coherent_averager
//   Trigger-aligned coherent averager for the ADC AXIS path. It sums 2^L
//   frames of SAMPLES signed samples in a block-RAM accumulator, then streams
//   out the per-index mean on m00_axis with full backpressure support. The
//   first frame of a run overwrites the RAM, so no clear pass is needed.
//
// Build option:
//   AVG_ROUND_EN  defined   -> round-half-up mean, saturated to DATA_W range
//                 undefined -> floor mean (arithmetic shift), no adder
//
// Ports:
//   s00_axis_aclk     in   sole clock
//   s00_axis_aresetn  in   asynchronous active-low reset
//   s00_axis_tvalid   in   ADC sample valid
//   s00_axis_tdata    in   ADC sample, signed in [DATA_W-1:0]
//   s00_axis_tlast    in   ADC end-of-frame marker (checked only)
//   s00_axis_tready   out  sample accept (low only while dumping)
//   trig_in           in   frame trigger, rising-edge sensitive
//   cfg_log2_avg      in   L, latched on the trigger that starts a run
//   m00_axis_tready   in   downstream ready
//   m00_axis_tvalid   out  averaged sample valid
//   m00_axis_tdata    out  mean, sign-extended to TDATA_WIDTH
//   m00_axis_tlast    out  high on output index SAMPLES-1
//   busy              out  high whenever the FSM is not idle
//   frame_err         out  1-cycle pulse on a tlast/index mismatch
// ---------------------------------------------------------------------------
module coherent_averager #(
  parameter int TDATA_WIDTH  = 32,
  parameter int DATA_W       = 16,
  parameter int SAMPLES      = 1024,
  parameter int MAX_LOG2_AVG = 10
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_aresetn,
  input  logic                              s00_axis_tvalid,
  input  logic [TDATA_WIDTH-1:0]            s00_axis_tdata,
  input  logic                              s00_axis_tlast,
  output logic                              s00_axis_tready,
  input  logic                              trig_in,
  input  logic [$clog2(MAX_LOG2_AVG+1)-1:0] cfg_log2_avg,
  input  logic                              m00_axis_tready,
  output logic                              m00_axis_tvalid,
  output logic [TDATA_WIDTH-1:0]            m00_axis_tdata,
  output logic                              m00_axis_tlast,
  output logic                              busy,
  output logic                              frame_err
);

  localparam int ACC_W = DATA_W + MAX_LOG2_AVG;
  localparam int LW    = $clog2(MAX_LOG2_AVG + 1);
  localparam int IW    = $clog2(SAMPLES);
  localparam int FW    = (MAX_LOG2_AVG > 0) ? MAX_LOG2_AVG : 1;
  localparam logic [LW-1:0] L_MAX    = LW'(MAX_LOG2_AVG);
  localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_ACCUM, S_WAIT_TRIG, S_DUMP
  } state_t;

  // Control state
  state_t                   state_q;
  logic                     trig_q;
  logic [LW-1:0]            l_q;
  logic [FW-1:0]            frame_cnt_q;
  logic [IW-1:0]            idx_q;
  logic                     frame_err_q;

  // Read-modify-write pipeline (stage 2 = write)
  logic                     p_valid_q;
  logic [IW-1:0]            p_idx_q;
  logic signed [DATA_W-1:0] p_x_q;
  logic                     p_first_q;
  logic                     fwd_hit_q;
  logic signed [ACC_W-1:0]  fwd_data_q;

  // Accumulator RAM with registered read
  logic signed [ACC_W-1:0]  acc_ram [SAMPLES];
  logic signed [ACC_W-1:0]  rd_data_q;

  // Dump read side and 2-entry skid buffer
  logic [IW-1:0]            rd_addr_q;
  logic                     rd_done_q;
  logic                     rd_inflight_q;
  logic                     rd_last_q;
  logic [DATA_W-1:0]        fifo_data_q [2];
  logic                     fifo_last_q [2];
  logic                     wr_ptr_q;
  logic                     rd_ptr_q;
  logic [1:0]               cnt_q;

  // Combinational
  logic                     trig_edge;
  logic                     in_beat;
  logic                     acc_beat;
  logic                     last_idx;
  logic [FW:0]              pow_l;
  logic [FW-1:0]            last_frame;
  logic [LW-1:0]            l_clamped;
  logic                     out_beat;
  logic [2:0]               occ;
  logic                     rd_issue;
  logic                     rd_en;
  logic [IW-1:0]            rd_addr_d;
  logic signed [ACC_W-1:0]  acc_op;
  logic signed [ACC_W-1:0]  wr_data_d;
  logic [DATA_W-1:0]        mean_d;

  // Only the low DATA_W bits of the input word carry the sample.
  generate
    if (TDATA_WIDTH > DATA_W) begin : g_unused_tdata
      logic unused_tdata_hi;
      assign unused_tdata_hi = ^s00_axis_tdata[TDATA_WIDTH-1:DATA_W];
    end
  endgenerate

  always_comb begin
    trig_edge  = trig_in && !trig_q;
    in_beat    = s00_axis_tvalid && s00_axis_tready;
    acc_beat   = in_beat && (state_q == S_ACCUM);
    last_idx   = (idx_q == LAST_IDX);
    // 2^L - 1 frames index; at L == FW the low bits of 2^L are 0 and wrap to all ones.
    pow_l      = (FW+1)'(1) << l_q;
    last_frame = pow_l[FW-1:0] - FW'(1);
    l_clamped  = (cfg_log2_avg > L_MAX) ? L_MAX : cfg_log2_avg;
    out_beat   = m00_axis_tvalid && m00_axis_tready;
    // Buffer occupancy after this cycle's pop, counting the read in flight.
    occ        = {1'b0, cnt_q} + {2'b0, rd_inflight_q} - {2'b0, out_beat};
    rd_issue   = (state_q == S_DUMP) && !rd_done_q && (occ < 3'd2);
    rd_en      = acc_beat || rd_issue;
    rd_addr_d  = (state_q == S_DUMP) ? rd_addr_q : idx_q;
    // If the read of this index raced with its own write, use the forwarded sum.
    acc_op     = fwd_hit_q ? fwd_data_q : rd_data_q;
    wr_data_d  = p_first_q ? ACC_W'(p_x_q) : acc_op + ACC_W'(p_x_q);
  end

`ifdef AVG_ROUND_EN
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [ACC_W:0] bias;
  logic signed [ACC_W:0] rnd_sum;
  logic signed [ACC_W:0] rnd_shift;

  always_comb begin
    bias      = (l_q != '0) ? ((ACC_W+1)'(1) << (l_q - LW'(1))) : '0;
    rnd_sum   = $signed({rd_data_q[ACC_W-1], rd_data_q}) + bias;
    rnd_shift = rnd_sum >>> l_q;
    if (rnd_shift > SAT_MAX) begin
      mean_d = DATA_W'(SAT_MAX);
    end else if (rnd_shift < SAT_MIN) begin
      mean_d = DATA_W'(SAT_MIN);
    end else begin
      mean_d = DATA_W'(rnd_shift);
    end
  end
`else
  always_comb begin
    mean_d = DATA_W'(rd_data_q >>> l_q);
  end
`endif

  // Accumulator RAM: one write port (pipeline stage 2), one registered read.
  always_ff @(posedge s00_axis_aclk) begin
    if (p_valid_q) begin
      acc_ram[p_idx_q] <= wr_data_d;
    end
    if (rd_en) begin
      rd_data_q <= acc_ram[rd_addr_d];
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q       <= S_IDLE;
      trig_q        <= 1'b0;
      l_q           <= '0;
      frame_cnt_q   <= '0;
      idx_q         <= '0;
      frame_err_q   <= 1'b0;
      p_valid_q     <= 1'b0;
      p_idx_q       <= '0;
      p_x_q         <= '0;
      p_first_q     <= 1'b0;
      fwd_hit_q     <= 1'b0;
      fwd_data_q    <= '0;
      rd_addr_q     <= '0;
      rd_done_q     <= 1'b0;
      rd_inflight_q <= 1'b0;
      rd_last_q     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      trig_q      <= trig_in;
      frame_err_q <= 1'b0;

      // Stage 1 -> stage 2 of the read-modify-write
      p_valid_q <= acc_beat;
      if (acc_beat) begin
        p_idx_q    <= idx_q;
        p_x_q      <= s00_axis_tdata[DATA_W-1:0];
        p_first_q  <= (frame_cnt_q == '0);
        fwd_hit_q  <= p_valid_q && (p_idx_q == idx_q);
        fwd_data_q <= wr_data_d;
      end

      // Dump reads feed the skid buffer one cycle later
      rd_inflight_q <= rd_issue;
      if (rd_issue) begin
        rd_last_q <= (rd_addr_q == LAST_IDX);
        if (rd_addr_q == LAST_IDX) begin
          rd_addr_q <= '0;
          rd_done_q <= 1'b1;
        end else begin
          rd_addr_q <= rd_addr_q + IW'(1);
        end
      end
      if (rd_inflight_q) begin
        fifo_data_q[wr_ptr_q] <= mean_d;
        fifo_last_q[wr_ptr_q] <= rd_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (out_beat) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, rd_inflight_q} - {1'b0, out_beat};

      case (state_q)
        S_IDLE: begin
          if (trig_edge) begin
            l_q         <= l_clamped;
            frame_cnt_q <= '0;
            idx_q       <= '0;
            state_q     <= S_ARMED;
          end
        end
        S_ARMED: begin
          state_q <= S_ACCUM;
        end
        S_ACCUM: begin
          if (in_beat) begin
            // Mismatch is only reported; idx alone defines the frame.
            frame_err_q <= (s00_axis_tlast != last_idx);
            if (last_idx) begin
              idx_q       <= '0;
              frame_cnt_q <= frame_cnt_q + FW'(1);
              if (frame_cnt_q == last_frame) begin
                state_q   <= S_DUMP;
                rd_addr_q <= '0;
                rd_done_q <= 1'b0;
              end else begin
                state_q <= S_WAIT_TRIG;
              end
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        S_WAIT_TRIG: begin
          if (trig_edge) begin
            state_q <= S_ARMED;
          end
        end
        S_DUMP: begin
          if (out_beat && m00_axis_tlast) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s00_axis_tready = (state_q != S_DUMP);
  assign busy            = (state_q != S_IDLE);
  assign frame_err       = frame_err_q;
  assign m00_axis_tvalid = (cnt_q != 2'd0);
  assign m00_axis_tlast  = m00_axis_tvalid && fifo_last_q[rd_ptr_q];
  assign m00_axis_tdata  = m00_axis_tvalid ? TDATA_WIDTH'($signed(fifo_data_q[rd_ptr_q])) : '0;

endmodule
